// File: rtl/VX_gpu_pkg.sv
// Shared GPU types for the kernel management unit.
// Task payload, credit width and dispatcher state encoding.
package VX_gpu_pkg;

  localparam int KMU_NUM_CORES  = 4;
  localparam int KMU_ADDR_WIDTH = 32;
  localparam int KMU_GID_WIDTH  = 16;
  localparam int KMU_CREDITS    = 2;
  localparam int KMU_CREDIT_W   = $clog2(KMU_CREDITS + 1);

  typedef struct packed {
    logic [KMU_ADDR_WIDTH-1:0] pc;
    logic [KMU_ADDR_WIDTH-1:0] arg;
    logic [KMU_GID_WIDTH-1:0]  group_id;
  } kmu_task_t;

  typedef enum logic [1:0] {
    KMU_IDLE,
    KMU_DISPATCH,
    KMU_DRAIN,
    KMU_FINISH
  } kmu_state_e;

endpackage

// File: rtl/kmu_credit_picker.sv
// Rotating-priority select over the per-core credit mask.
// Returns the first set core at or after start, wrapping around.
module kmu_credit_picker #(
  parameter int NUM_CORES = 4,
  parameter int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] mask,
  input  logic [IW-1:0]        start,
  output logic                 found,
  output logic [IW-1:0]        idx
);

  function automatic logic [IW-1:0] wrap(
    input logic [IW-1:0] s,
    input int            off
  );
    int v;
    v = int'(s) + off;
    if (v >= NUM_CORES) v = v - NUM_CORES;
    return IW'(v);
  endfunction

  // Scan farthest-first so the nearest candidate wins.
  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (mask[wrap(start, i)]) begin
        found = 1'b1;
        idx   = wrap(start, i);
      end
    end
  end

endmodule

// File: rtl/kmu_task_dispatch.sv
// Splits one kernel launch into per-workgroup tasks.
// Round-robin over cores, gated by per-core credits.
module kmu_task_dispatch
  import VX_gpu_pkg::*;
#(
  parameter int NUM_CORES  = KMU_NUM_CORES,
  parameter int ADDR_WIDTH = KMU_ADDR_WIDTH,
  parameter int GID_WIDTH  = KMU_GID_WIDTH,
  parameter int CREDITS    = KMU_CREDITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  launch_valid,
  output logic                  launch_ready,
  input  logic [ADDR_WIDTH-1:0] launch_pc,
  input  logic [ADDR_WIDTH-1:0] launch_arg,
  input  logic [GID_WIDTH-1:0]  launch_num_groups,
  output logic [NUM_CORES-1:0]  task_valid,
  input  logic [NUM_CORES-1:0]  task_ready,
  output kmu_task_t             task_data,
  input  logic [NUM_CORES-1:0]  task_done,
  output logic                  busy,
  output logic                  done,
  output logic [GID_WIDTH-1:0]  groups_issued
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam int OW = GID_WIDTH + 1;
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  kmu_state_e state;
  kmu_state_e state_n;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] arg_q;
  logic [GID_WIDTH-1:0]  num_q;
  logic [GID_WIDTH-1:0]  next_gid;
  logic [OW-1:0]         outstanding;
  logic [CW-1:0]         credit [NUM_CORES];
  logic [IW-1:0]         rr_ptr;

  logic [NUM_CORES-1:0]  avail;
  logic [NUM_CORES-1:0]  done_ok;
  logic                  found;
  logic [IW-1:0]         pick;
  logic                  fire;
  logic                  hs;
  logic                  load;
  logic                  last_hs;
  logic [OW-1:0]         done_cnt;
  logic [OW-1:0]         out_sum;
  logic [OW-1:0]         out_n;

  kmu_credit_picker #(
    .NUM_CORES (NUM_CORES),
    .IW        (IW)
  ) u_picker (
    .mask  (avail),
    .start (rr_ptr),
    .found (found),
    .idx   (pick)
  );

  assign launch_ready = (state == KMU_IDLE) && reset;
  assign busy         = (state != KMU_IDLE);
  assign done         = (state == KMU_FINISH);

  assign fire = launch_valid && launch_ready;
  assign hs   = |(task_valid & task_ready);

  assign load = (state == KMU_DISPATCH)
             && (!(|task_valid) || hs)
             && (next_gid < num_q)
             && found;

  assign last_hs = hs
                && (({1'b0, groups_issued} + OW'(1))
                    == {1'b0, num_q});

  // Completions against a full credit are spurious and dropped.
  always_comb begin
    avail    = '0;
    done_ok  = '0;
    done_cnt = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      avail[c]   = (credit[c] != '0);
      done_ok[c] = task_done[c] && (credit[c] != CMAX);
      if (done_ok[c] && state != KMU_IDLE)
        done_cnt = done_cnt + OW'(1);
    end
  end

  always_comb begin
    out_sum = outstanding + OW'(hs);
    out_n   = '0;
    if (state != KMU_IDLE && done_cnt <= out_sum)
      out_n = out_sum - done_cnt;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      KMU_IDLE: begin
        if (fire)
          state_n = (launch_num_groups == '0)
                  ? KMU_FINISH : KMU_DISPATCH;
      end
      KMU_DISPATCH: begin
        if (last_hs) state_n = KMU_DRAIN;
      end
      KMU_DRAIN: begin
        if (out_n == '0) state_n = KMU_FINISH;
      end
      KMU_FINISH: state_n = KMU_IDLE;
      default:    state_n = KMU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= KMU_IDLE;
      task_valid    <= '0;
      groups_issued <= '0;
      outstanding   <= '0;
      next_gid      <= '0;
      rr_ptr        <= '0;
      for (int c = 0; c < NUM_CORES; c++)
        credit[c] <= CMAX;
    end else begin
      state       <= state_n;
      outstanding <= fire ? '0 : out_n;

      for (int c = 0; c < NUM_CORES; c++) begin
        credit[c] <= credit[c]
                   - CW'(load && pick == IW'(c))
                   + CW'(done_ok[c]);
      end

      if (fire) begin
        pc_q          <= launch_pc;
        arg_q         <= launch_arg;
        num_q         <= launch_num_groups;
        next_gid      <= '0;
        groups_issued <= '0;
      end else if (hs) begin
        groups_issued <= groups_issued + 1'b1;
      end

      if (load) begin
        task_valid         <= '0;
        task_valid[pick]   <= 1'b1;
        task_data.pc       <= pc_q;
        task_data.arg      <= arg_q;
        task_data.group_id <= next_gid;
        next_gid           <= next_gid + 1'b1;
        rr_ptr <= (int'(pick) == NUM_CORES - 1)
                ? '0 : pick + 1'b1;
      end else if (hs) begin
        task_valid <= '0;
      end

      for (int c = 0; c < NUM_CORES; c++) begin
        if (task_done[c])
          assert (credit[c] != CMAX)
            else $error("kmu: spurious task_done on core %0d", c);
      end
    end
  end

endmodule

// File: tb/tb_kmu_task_dispatch.sv
// Directed bench for kmu_task_dispatch.
// Main instance uses CREDITS=2, a second one CREDITS=1.
module tb_kmu_task_dispatch;
  import VX_gpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        launch_valid;
  logic        launch_ready;
  logic [31:0] launch_pc;
  logic [31:0] launch_arg;
  logic [15:0] launch_num_groups;
  logic [3:0]  task_valid;
  logic [3:0]  task_ready;
  kmu_task_t   task_data;
  logic [3:0]  task_done;
  logic        busy;
  logic        done;
  logic [15:0] groups_issued;

  logic        c1_rst_n;
  logic        c1_launch_valid;
  logic        c1_launch_ready;
  logic [15:0] c1_num_groups;
  logic [3:0]  c1_task_valid;
  logic [3:0]  c1_task_ready;
  kmu_task_t   c1_task_data;
  logic [3:0]  c1_task_done;
  logic        c1_busy;
  logic        c1_done;
  logic [15:0] c1_groups_issued;

  int checks = 0;
  int errors = 0;

  kmu_task_dispatch dut (
    .clk               (clk),
    .reset             (rst_n),
    .launch_valid      (launch_valid),
    .launch_ready      (launch_ready),
    .launch_pc         (launch_pc),
    .launch_arg        (launch_arg),
    .launch_num_groups (launch_num_groups),
    .task_valid        (task_valid),
    .task_ready        (task_ready),
    .task_data         (task_data),
    .task_done         (task_done),
    .busy              (busy),
    .done              (done),
    .groups_issued     (groups_issued)
  );

  kmu_task_dispatch #(.CREDITS(1)) dut1 (
    .clk               (clk),
    .reset             (c1_rst_n),
    .launch_valid      (c1_launch_valid),
    .launch_ready      (c1_launch_ready),
    .launch_pc         (32'h0000_4000),
    .launch_arg        (32'h0000_5000),
    .launch_num_groups (c1_num_groups),
    .task_valid        (c1_task_valid),
    .task_ready        (c1_task_ready),
    .task_data         (c1_task_data),
    .task_done         (c1_task_done),
    .busy              (c1_busy),
    .done              (c1_done),
    .groups_issued     (c1_groups_issued)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; c1_rst_n = 1'b0;
    launch_valid = 0; launch_pc = '0; launch_arg = '0;
    launch_num_groups = '0; task_ready = '0; task_done = '0;
    c1_launch_valid = 0; c1_num_groups = '0;
    c1_task_ready = '0; c1_task_done = '0;
    tick(); tick();
    checks++;
    if (task_valid !== 4'b0) begin errors++;
      $display("FAIL reset_valid: got %b want 0000", task_valid); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    checks++;
    if (groups_issued !== 16'd0) begin errors++;
      $display("FAIL reset_issued: got %0d want 0", groups_issued); end
    checks++;
    if (dut.state !== KMU_IDLE) begin errors++;
      $display("FAIL reset_state: got %0d want IDLE", dut.state); end
    rst_n = 1'b1; c1_rst_n = 1'b1;
    #1;
    checks++;
    if (launch_ready !== 1'b1 || c1_launch_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready: got %b%b want 11", launch_ready, c1_launch_ready); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (int'(dut.credit[c]) != 2) begin errors++;
        $display("FAIL reset_credit%0d: got %0d want 2", c, dut.credit[c]); end
    end
  endtask

  task automatic test_basic();
    int exp_cr [4];
    exp_cr = '{0, 0, 1, 1};
    launch_pc = 32'h8000_0000; launch_arg = 32'h1000_0040;
    launch_num_groups = 16'd6; launch_valid = 1'b1; task_ready = 4'hF;
    tick();
    launch_valid = 1'b0;
    checks++;
    if (dut.state !== KMU_DISPATCH || task_valid !== 4'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL basic_start: state %0d valid %b busy %b want DISPATCH 0000 1",
               dut.state, task_valid, busy); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (task_valid !== 4'(1 << (i % 4))) begin errors++;
        $display("FAIL basic_core gid%0d: got %b want %b", i, task_valid, 4'(1 << (i % 4))); end
      checks++;
      if (task_data.group_id !== 16'(i) || task_data.pc !== 32'h8000_0000
          || task_data.arg !== 32'h1000_0040) begin errors++;
        $display("FAIL basic_data gid%0d: got %h/%h/%0d", i,
                 task_data.pc, task_data.arg, task_data.group_id); end
      checks++;
      if (groups_issued !== 16'(i)) begin errors++;
        $display("FAIL basic_issued: got %0d want %0d", groups_issued, i); end
    end
    tick();
    checks++;
    if (dut.state !== KMU_DRAIN || task_valid !== 4'b0) begin errors++;
      $display("FAIL basic_drain: state %0d valid %b want DRAIN 0000", dut.state, task_valid); end
    checks++;
    if (groups_issued !== 16'd6 || busy !== 1'b1 || done !== 1'b0) begin errors++;
      $display("FAIL basic_status: issued %0d busy %b done %b want 6 1 0",
               groups_issued, busy, done); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (int'(dut.credit[c]) != exp_cr[c]) begin errors++;
        $display("FAIL basic_credit%0d: got %0d want %0d", c, dut.credit[c], exp_cr[c]); end
    end
  endtask

  task automatic test_completion();
    task_done = 4'b1111;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL compl_partial: done %b busy %b want 0 1", done, busy); end
    task_done = 4'b0011;
    tick();
    task_done = 4'b0000;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin errors++;
      $display("FAIL compl_done: done %b busy %b want 1 1", done, busy); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || launch_ready !== 1'b1) begin errors++;
      $display("FAIL compl_idle: done %b busy %b ready %b want 0 0 1",
               done, busy, launch_ready); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (int'(dut.credit[c]) != 2) begin errors++;
        $display("FAIL compl_credit%0d: got %0d want 2", c, dut.credit[c]); end
    end
  endtask

  task automatic test_zero_groups();
    launch_num_groups = 16'd0; launch_valid = 1'b1;
    tick();
    launch_valid = 1'b0;
    checks++;
    if (task_valid !== 4'b0 || busy !== 1'b1 || done !== 1'b1 || launch_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_finish: valid %b busy %b done %b ready %b want 0000 1 1 0",
               task_valid, busy, done, launch_ready); end
    tick();
    checks++;
    if (task_valid !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || launch_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_idle: valid %b busy %b done %b ready %b want 0000 0 0 1",
               task_valid, busy, done, launch_ready); end
  endtask

  task automatic test_backpressure();
    do_reset();
    launch_pc = 32'h0000_2000; launch_arg = 32'h0000_3000;
    launch_num_groups = 16'd1; launch_valid = 1'b1; task_ready = 4'b1110;
    tick();
    launch_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (task_valid !== 4'b0001 || task_data.group_id !== 16'd0
          || task_data.pc !== 32'h0000_2000) begin errors++;
        $display("FAIL bp_hold cyc%0d: valid %b gid %0d pc %h", k,
                 task_valid, task_data.group_id, task_data.pc); end
      checks++;
      if (groups_issued !== 16'd0) begin errors++;
        $display("FAIL bp_issued cyc%0d: got %0d want 0", k, groups_issued); end
      tick();
    end
    task_ready = 4'hF;
    tick();
    checks++;
    if (task_valid !== 4'b0 || groups_issued !== 16'd1 || dut.state !== KMU_DRAIN) begin
      errors++;
      $display("FAIL bp_accept: valid %b issued %0d state %0d want 0000 1 DRAIN",
               task_valid, groups_issued, dut.state); end
    task_done = 4'b0001;
    tick();
    task_done = 4'b0000;
    checks++;
    if (done !== 1'b1) begin errors++;
      $display("FAIL bp_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    launch_pc = 32'h0000_6000; launch_arg = 32'h0000_7000;
    launch_num_groups = 16'd8; launch_valid = 1'b1; task_ready = 4'b0111;
    tick();
    launch_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if (task_valid !== 4'b1000 || task_data.group_id !== 16'd3
        || groups_issued !== 16'd3) begin errors++;
      $display("FAIL mid_pending: valid %b gid %0d issued %0d want 1000 3 3",
               task_valid, task_data.group_id, groups_issued); end
    rst_n = 1'b0;
    tick();
    checks++;
    if (task_valid !== 4'b0 || busy !== 1'b0 || groups_issued !== 16'd0) begin errors++;
      $display("FAIL mid_reset: valid %b busy %b issued %0d want 0000 0 0",
               task_valid, busy, groups_issued); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (int'(dut.credit[c]) != 2) begin errors++;
        $display("FAIL mid_credit%0d: got %0d want 2", c, dut.credit[c]); end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (launch_ready !== 1'b1) begin errors++;
      $display("FAIL mid_ready: got %b want 1", launch_ready); end
    launch_num_groups = 16'd2; launch_valid = 1'b1; task_ready = 4'hF;
    tick();
    launch_valid = 1'b0;
    tick();
    checks++;
    if (task_valid !== 4'b0001 || task_data.group_id !== 16'd0) begin errors++;
      $display("FAIL mid_relaunch: valid %b gid %0d want 0001 0",
               task_valid, task_data.group_id); end
    tick(); tick();
    task_done = 4'b0011;
    tick();
    task_done = 4'b0000;
    checks++;
    if (done !== 1'b1) begin errors++;
      $display("FAIL mid_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_credit_exhaust();
    c1_num_groups = 16'd8; c1_launch_valid = 1'b1; c1_task_ready = 4'hF;
    tick();
    c1_launch_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (c1_task_valid !== 4'(1 << i) || c1_task_data.group_id !== 16'(i)) begin errors++;
        $display("FAIL cx_issue gid%0d: valid %b gid %0d", i,
                 c1_task_valid, c1_task_data.group_id); end
    end
    tick();
    checks++;
    if (c1_task_valid !== 4'b0 || c1_groups_issued !== 16'd4) begin errors++;
      $display("FAIL cx_stall: valid %b issued %0d want 0000 4",
               c1_task_valid, c1_groups_issued); end
    tick();
    checks++;
    if (c1_task_valid !== 4'b0) begin errors++;
      $display("FAIL cx_stall2: valid %b want 0000", c1_task_valid); end
    c1_task_done = 4'b0100;
    tick();
    c1_task_done = 4'b0000;
    checks++;
    if (c1_task_valid !== 4'b0) begin errors++;
      $display("FAIL cx_credit_cycle: valid %b want 0000", c1_task_valid); end
    tick();
    checks++;
    if (c1_task_valid !== 4'b0100 || c1_task_data.group_id !== 16'd4) begin errors++;
      $display("FAIL cx_resume: valid %b gid %0d want 0100 4",
               c1_task_valid, c1_task_data.group_id); end
    c1_rst_n = 1'b0;
    tick();
    c1_rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_completion();
    test_zero_groups();
    test_backpressure();
    test_reset_mid();
    test_credit_exhaust();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
